instr_exec_unit: RTL and testbench



---
 rtl/instr_register_pkg.sv | 39 +++
 rtl/instr_exec_unit_divider.sv | 66 ++++++
 rtl/instr_exec_unit.sv | 121 ++++++++++++
 tb/tb_instr_exec_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// rtl/instr_register_pkg.sv - shared instruction types for the instruction register and its execute unit
package instr_register_pkg;

    localparam int OP_W  = 32;
    localparam int RES_W = 64;

    typedef enum logic [3:0] {
        PASSA = 4'd0,
        PASSB = 4'd1,
        ADD   = 4'd2,
        SUB   = 4'd3,
        MULT  = 4'd4,
        DIV   = 4'd5,
        MOD   = 4'd6,
        ZERO  = 4'd7
    } opcode_t;

    typedef logic signed [OP_W-1:0]  operand_t;
    typedef logic signed [RES_W-1:0] operand_d;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        operand_d rezultat;
    } instruction_t;

    // State names carry a prefix because DIV is already an opcode literal in this package.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } exec_state_t;

    function automatic logic is_div_op(opcode_t o);
        return (o == DIV) || (o == MOD);
    endfunction

endpackage

// File: rtl/instr_exec_unit_divider.sv
// rtl/instr_exec_unit_divider.sv - fixed-latency signed restoring divider, one quotient bit per cycle
module iter_divider #(
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic signed [W-1:0] dividend,
    input  logic signed [W-1:0] divisor,
    output logic signed [W:0]   quotient,
    output logic signed [W-1:0] remainder,
    output logic                done
);
    localparam int CW = $clog2(W);

    logic [W-1:0]  rem_q;
    logic [W-1:0]  quo_q;
    logic [W:0]    dvs_q;
    logic [CW-1:0] cnt_q;
    logic          running_q, neg_q_q, neg_r_q;

    logic [W:0]    shifted;
    logic [W-1:0]  rem_n, quo_n, mag_a;
    logic [W:0]    mag_b;
    logic          ge;

    // The most negative dividend's magnitude (2^(W-1)) still fits W unsigned bits.
    always_comb begin
        mag_a     = dividend[W-1] ? (~dividend + 1'b1) : dividend;
        mag_b     = {1'b0, (divisor[W-1] ? (~divisor + 1'b1) : divisor)};
        shifted   = {rem_q, quo_q[W-1]};
        ge        = shifted >= dvs_q;
        rem_n     = W'(ge ? (shifted - dvs_q) : shifted);
        quo_n     = {quo_q[W-2:0], ge};
        done      = running_q && (cnt_q == CW'(W-1));
        quotient  = neg_q_q ? -$signed({1'b0, quo_n}) : $signed({1'b0, quo_n});
        remainder = neg_r_q ? -$signed(rem_n) : $signed(rem_n);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
        end else if (start) begin
            rem_q     <= '0;
            quo_q     <= mag_a;
            dvs_q     <= mag_b;
            cnt_q     <= '0;
            running_q <= 1'b1;
            neg_q_q   <= dividend[W-1] ^ divisor[W-1];
            neg_r_q   <= dividend[W-1];
        end else if (running_q) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt_q <= cnt_q + CW'(1);
            if (done)
                running_q <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_exec_unit.sv
// rtl/instr_exec_unit.sv - executes instructions from the instruction register onto a valid/ready result stream
module instr_exec_unit
    import instr_register_pkg::*;
#(
    parameter int OP_WIDTH  = 32,
    parameter int RES_WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  instruction_t                in_instr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output opcode_t                     out_opc,
    output logic signed [RES_WIDTH-1:0] out_result,
    output logic                        out_div_by_zero,
    output logic                        busy
);
    exec_state_t state_q, state_d;

    logic signed [OP_WIDTH-1:0]  op_a, op_b;
    logic signed [RES_WIDTH-1:0] a_ext, b_ext, single_res, quo_ext, rem_ext;
    logic signed [OP_WIDTH:0]    div_quo;
    logic signed [OP_WIDTH-1:0]  div_rem;
    logic                        div_done, div_start, accept, is_div, b_zero;
    logic                        unused_rezultat;

    opcode_t                     out_opc_q;
    logic signed [RES_WIDTH-1:0] out_result_q;
    logic                        dbz_q;

    assign op_a            = in_instr.op_a;
    assign op_b            = in_instr.op_b;
    assign unused_rezultat = ^in_instr.rezultat;
    assign accept          = in_valid && in_ready;
    assign is_div          = is_div_op(in_instr.opc);
    assign b_zero          = (op_b == '0);
    assign div_start       = accept && is_div && !b_zero;

    always_comb begin
        a_ext   = {{(RES_WIDTH-OP_WIDTH){op_a[OP_WIDTH-1]}}, op_a};
        b_ext   = {{(RES_WIDTH-OP_WIDTH){op_b[OP_WIDTH-1]}}, op_b};
        quo_ext = {{(RES_WIDTH-OP_WIDTH-1){div_quo[OP_WIDTH]}}, div_quo};
        rem_ext = {{(RES_WIDTH-OP_WIDTH){div_rem[OP_WIDTH-1]}}, div_rem};
        case (in_instr.opc)
            PASSA:   single_res = a_ext;
            PASSB:   single_res = b_ext;
            ADD:     single_res = a_ext + b_ext;
            SUB:     single_res = a_ext - b_ext;
            MULT:    single_res = a_ext * b_ext;
            default: single_res = '0;
        endcase
    end

    iter_divider #(.W(OP_WIDTH)) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (div_start),
        .dividend  (op_a),
        .divisor   (op_b),
        .quotient  (div_quo),
        .remainder (div_rem),
        .done      (div_done)
    );

    always_ff @(posedge clk) begin
        if (!reset_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept)
                    state_d = div_start ? S_DIV : S_DONE;
                else if (state_q == S_IDLE || out_ready)
                    state_d = S_IDLE;
            end
            S_DIV:   if (div_done) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state_q != S_IDLE);
        case (state_q)
            S_IDLE:  in_ready = 1'b1;
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    // Results only change on a handoff edge or on divider completion, so they hold while stalled.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_result_q <= '0;
            out_opc_q    <= PASSA;
            dbz_q        <= 1'b0;
        end else if (accept) begin
            out_result_q <= single_res;
            out_opc_q    <= in_instr.opc;
            dbz_q        <= is_div && b_zero;
        end else if (div_done && state_q == S_DIV) begin
            out_result_q <= (out_opc_q == DIV) ? quo_ext : rem_ext;
        end
    end

    assign out_result      = out_result_q;
    assign out_opc         = out_opc_q;
    assign out_div_by_zero = dbz_q;

endmodule

// File: tb/tb_instr_exec_unit.sv
// tb/tb_instr_exec_unit.sv - directed and streaming self-checking bench for instr_exec_unit
module tb_instr_exec_unit;
    import instr_register_pkg::*;

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    instruction_t in_instr;
    logic         out_valid;
    logic         out_ready;
    opcode_t      out_opc;
    logic signed [63:0] out_result;
    logic         out_div_by_zero;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    instr_exec_unit #(.OP_WIDTH(32), .RES_WIDTH(64)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instr        (in_instr),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_opc         (out_opc),
        .out_result      (out_result),
        .out_div_by_zero (out_div_by_zero),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input opcode_t o, input int a, input int b);
        in_valid          = 1'b1;
        in_instr.opc      = o;
        in_instr.op_a     = a;
        in_instr.op_b     = b;
        in_instr.rezultat = '0;
    endtask

    function automatic longint golden(input opcode_t o, input int a, input int b);
        longint la = a;
        longint lb = b;
        case (o)
            PASSA:   return la;
            PASSB:   return lb;
            ADD:     return la + lb;
            SUB:     return la - lb;
            MULT:    return la * lb;
            DIV:     return (lb == 0) ? 64'sd0 : la / lb;
            MOD:     return (lb == 0) ? 64'sd0 : la % lb;
            default: return 64'sd0;
        endcase
    endfunction

    // Expects out_ready=1; valid must be absent for cycles 1..32 and present at cycle 33.
    task automatic run_div(input opcode_t o, input int a, input int b, input logic [63:0] exp,
                           input string tag);
        logic stall_ok;
        drive(o, a, b);
        tick();
        in_valid = 1'b0;
        stall_ok = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) stall_ok = 1'b0;
            tick();
        end
        chk({tag, "_stall"}, stall_ok, 1'b1);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk(tag, out_result, exp);
        tick();
    endtask

    instruction_t mem [20];
    longint       exp_q [$];
    opcode_t      opc_q [$];

    initial begin
        logic hold_ok;
        logic noval;
        int   sent;
        int   got;

        // reset with a valid instruction presented
        reset_n   = 1'b0;
        out_ready = 1'b1;
        drive(ADD, 5, 6);
        tick();
        tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_result", out_result, 64'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_opc", out_opc, PASSA);
        chk("rst_dbz", out_div_by_zero, 1'b0);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        tick();

        // single-cycle ops back to back
        drive(ADD, -15, 7);
        tick();
        chk("add_valid", out_valid, 1'b1);
        chk("add_result", out_result, -64'sd8);
        chk("add_opc", out_opc, ADD);
        drive(MULT, -3, 15);
        tick();
        chk("mult_valid", out_valid, 1'b1);
        chk("mult_result", out_result, -64'sd45);
        in_valid = 1'b0;
        tick();
        chk("drain_valid", out_valid, 1'b0);

        // iterative divide
        run_div(DIV, -15, 4, -64'sd3, "div_m15_4");
        run_div(MOD, -15, 4, -64'sd3, "mod_m15_4");
        run_div(DIV, 32'h8000_0000, -1, 64'h0000_0000_8000_0000, "div_min_m1");
        run_div(MOD, 32'h8000_0000, -1, 64'd0, "mod_min_m1");
        run_div(DIV, 7, -2, -64'sd3, "div_7_m2");
        run_div(MOD, 7, -2, 64'sd1, "mod_7_m2");

        drive(MULT, 32'h8000_0000, 32'h8000_0000);
        tick();
        chk("mult_min_min", out_result, 64'h4000_0000_0000_0000);
        in_valid = 1'b0;
        tick();

        // divide by zero then flag cleared by next op
        drive(DIV, 9, 0);
        tick();
        chk("dbz_valid", out_valid, 1'b1);
        chk("dbz_result", out_result, 64'd0);
        chk("dbz_flag", out_div_by_zero, 1'b1);
        drive(ADD, 1, 2);
        tick();
        chk("dbz_clear_flag", out_div_by_zero, 1'b0);
        chk("dbz_clear_result", out_result, 64'd3);
        in_valid = 1'b0;
        tick();

        // backpressure
        drive(SUB, 3, 10);
        out_ready = 1'b0;
        tick();
        drive(ADD, 5, 5);
        hold_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || out_result !== -64'sd7 || in_ready !== 1'b0) hold_ok = 1'b0;
            tick();
        end
        chk("bp_hold", hold_ok, 1'b1);
        chk("bp_result", out_result, -64'sd7);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready", in_ready, 1'b1);
        tick();
        chk("bp_next_result", out_result, 64'd10);
        in_valid = 1'b0;
        tick();

        // streaming with random out_ready
        for (int i = 0; i < 20; i++) begin
            mem[i].opc      = opcode_t'($urandom_range(0, 7));
            mem[i].op_a     = ($urandom_range(0, 1) == 1) ? int'($urandom) : int'($urandom_range(0, 40)) - 20;
            mem[i].op_b     = ($urandom_range(0, 1) == 1) ? int'($urandom) : int'($urandom_range(0, 12)) - 6;
            mem[i].rezultat = '0;
        end
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 3000 && got < 20; cyc++) begin
            out_ready = ($urandom_range(0, 1) == 1);
            in_valid  = (sent < 20);
            if (sent < 20) in_instr = mem[sent];
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("stream_extra_out", out_valid, 1'b0);
                end else begin
                    chk("stream_result", out_result, exp_q.pop_front());
                    chk("stream_opc", out_opc, opc_q.pop_front());
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(golden(mem[sent].opc, mem[sent].op_a, mem[sent].op_b));
                opc_q.push_back(mem[sent].opc);
                sent++;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("stream_count", got, 20);
        chk("stream_leftover", exp_q.size(), 0);

        // reset in the middle of a divide
        out_ready = 1'b1;
        tick();
        drive(DIV, 100, 7);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset_n = 1'b0;
        tick();
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_valid", out_valid, 1'b0);
        reset_n = 1'b1;
        noval   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (out_valid !== 1'b0) noval = 1'b0;
            tick();
        end
        chk("mid_rst_no_stray", noval, 1'b1);
        drive(PASSB, 5, -2);
        tick();
        chk("post_rst_passb", out_result, -64'sd2);
        in_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
